// File: rtl/usb_tx_sequencer.sv
// -----------------------------------------------------------------------------
// usb_tx_sequencer
//
// Transmit-side controller that sits between a byte source and the
// bit_stuffer -> NRZI encoder path. It produces the bit-rate tick,
// serialises the SYNC byte and then the host bytes LSB-first as raw
// (unstuffed) bits, inserts the bit times that the stuffer asks for, and
// finishes every packet with EOP (SE0 for EOP_SE0_BITS bit times, then one
// bit time of J) before going back to idle.
//
// Ports:
//   clk         in   1  system clock
//   rst         in   1  synchronous, active-high reset
//   tx_valid    in   1  byte source has tx_data/tx_last valid
//   tx_data     in   8  byte to send, LSB transmitted first
//   tx_last     in   1  tx_data is the final byte of the packet
//   tx_ready    out  1  1-cycle pulse: byte accepted (tx_valid & tx_ready)
//   stuff_next  in   1  from bit_stuffer, sampled on bit_tick: next bit time
//                       is a stuffed bit
//   bit_tick    out  1  1-cycle pulse on the last clk of each bit time
//   raw_bit     out  1  current unstuffed bit to the bit_stuffer
//   raw_valid   out  1  stuffer/encoder path is live (SYNC/DATA/TAIL)
//   eop_se0     out  1  line driven SE0 (bypasses the encoder)
//   eop_j       out  1  line driven J
//   busy        out  1  any state other than IDLE
//   tx_err      out  1  1-cycle pulse on underrun at a byte boundary
// -----------------------------------------------------------------------------
module usb_tx_sequencer #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter logic [7:0]  SYNC_PATTERN = 8'h80,
    parameter int unsigned EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       stuff_next,
    output logic       bit_tick,
    output logic       raw_bit,
    output logic       raw_valid,
    output logic       eop_se0,
    output logic       eop_j,
    output logic       busy,
    output logic       tx_err
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int EOP_W = $clog2(EOP_SE0_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [EOP_W-1:0] EOP_MAX  = EOP_W'(EOP_SE0_BITS - 1);
    localparam logic [EOP_W-1:0] EOP_ZERO = EOP_W'(0);
    localparam logic [EOP_W-1:0] EOP_ONE  = EOP_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_DATA    = 3'd2,
        ST_TAIL    = 3'd3,
        ST_EOP_SE0 = 3'd4,
        ST_EOP_J   = 3'd5
    } state_e;

    state_e           state_r;
    state_e           state_nx_s;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_nx_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_nx_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nx_s;
    logic             stuff_slot_r;
    logic             stuff_slot_nx_s;
    logic             last_flag_r;
    logic             last_flag_nx_s;
    logic [EOP_W-1:0] eop_cnt_r;
    logic [EOP_W-1:0] eop_cnt_nx_s;

    logic             busy_s;
    logic             tick_s;
    logic             tx_ready_s;
    logic             tx_err_s;

    // State and datapath registers; synchronous reset aborts any packet at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            div_r        <= DIV_ZERO;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            stuff_slot_r <= 1'b0;
            last_flag_r  <= 1'b0;
            eop_cnt_r    <= EOP_ZERO;
        end else begin
            state_r      <= state_nx_s;
            div_r        <= div_nx_s;
            bit_idx_r    <= bit_idx_nx_s;
            shift_r      <= shift_nx_s;
            stuff_slot_r <= stuff_slot_nx_s;
            last_flag_r  <= last_flag_nx_s;
            eop_cnt_r    <= eop_cnt_nx_s;
        end
    end

    // Bit-rate divider: free-runs while a packet is in flight, parked at 0 in IDLE.
    always_comb begin
        busy_s   = (state_r != ST_IDLE);
        tick_s   = busy_s && (div_r == DIV_MAX);
        div_nx_s = div_r;
        if (!busy_s) begin
            div_nx_s = DIV_ZERO;
        end else if (tick_s) begin
            div_nx_s = DIV_ZERO;
        end else begin
            div_nx_s = div_r + DIV_ONE;
        end
    end

    // Next-state logic and the byte handshake, evaluated on bit boundaries.
    always_comb begin
        state_nx_s      = state_r;
        bit_idx_nx_s    = bit_idx_r;
        shift_nx_s      = shift_r;
        stuff_slot_nx_s = stuff_slot_r;
        last_flag_nx_s  = last_flag_r;
        eop_cnt_nx_s    = eop_cnt_r;
        tx_ready_s      = 1'b0;
        tx_err_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // The first byte is not taken here; it is accepted at SYNC end.
                if (tx_valid) begin
                    state_nx_s      = ST_SYNC;
                    shift_nx_s      = SYNC_PATTERN;
                    bit_idx_nx_s    = 3'd0;
                    stuff_slot_nx_s = 1'b0;
                    last_flag_nx_s  = 1'b0;
                    eop_cnt_nx_s    = EOP_ZERO;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end

            ST_SYNC, ST_DATA: begin
                if (!tick_s) begin
                    state_nx_s = state_r;
                end else if (stuff_slot_r) begin
                    // The bit time that just ended carried a stuffed bit:
                    // nothing is consumed, the same raw bit stays presented.
                    stuff_slot_nx_s = stuff_next;
                end else if (bit_idx_r != 3'd7) begin
                    shift_nx_s      = {1'b0, shift_r[7:1]};
                    bit_idx_nx_s    = bit_idx_r + 3'd1;
                    stuff_slot_nx_s = stuff_next;
                end else begin
                    // Byte boundary: the eighth bit of SYNC or of a data byte ends.
                    shift_nx_s   = {1'b0, shift_r[7:1]};
                    bit_idx_nx_s = 3'd0;
                    if ((state_r == ST_DATA) && last_flag_r) begin
                        // A stuff request after the final data bit becomes TAIL.
                        stuff_slot_nx_s = 1'b0;
                        state_nx_s      = stuff_next ? ST_TAIL : ST_EOP_SE0;
                        eop_cnt_nx_s    = EOP_ZERO;
                    end else if (tx_valid) begin
                        tx_ready_s      = 1'b1;
                        shift_nx_s      = tx_data;
                        last_flag_nx_s  = tx_last;
                        stuff_slot_nx_s = stuff_next;
                        state_nx_s      = ST_DATA;
                    end else begin
                        // Underrun: close the packet straight away, any stuff
                        // request for the missing byte is dropped.
                        tx_err_s        = 1'b1;
                        stuff_slot_nx_s = 1'b0;
                        state_nx_s      = ST_EOP_SE0;
                        eop_cnt_nx_s    = EOP_ZERO;
                    end
                end
            end

            ST_TAIL: begin
                if (tick_s) begin
                    state_nx_s      = ST_EOP_SE0;
                    stuff_slot_nx_s = 1'b0;
                    eop_cnt_nx_s    = EOP_ZERO;
                end else begin
                    state_nx_s = ST_TAIL;
                end
            end

            ST_EOP_SE0: begin
                if (!tick_s) begin
                    state_nx_s = ST_EOP_SE0;
                end else if (eop_cnt_r == EOP_MAX) begin
                    state_nx_s   = ST_EOP_J;
                    eop_cnt_nx_s = EOP_ZERO;
                end else begin
                    eop_cnt_nx_s = eop_cnt_r + EOP_ONE;
                end
            end

            ST_EOP_J: begin
                // tx_valid is ignored here; a new packet can start from IDLE.
                if (tick_s) begin
                    state_nx_s     = ST_IDLE;
                    last_flag_nx_s = 1'b0;
                end else begin
                    state_nx_s = ST_EOP_J;
                end
            end

            default: begin
                state_nx_s      = ST_IDLE;
                bit_idx_nx_s    = 3'd0;
                shift_nx_s      = 8'h00;
                stuff_slot_nx_s = 1'b0;
                last_flag_nx_s  = 1'b0;
                eop_cnt_nx_s    = EOP_ZERO;
            end
        endcase
    end

    // Output decode from the state register and the boundary handshake.
    always_comb begin
        busy      = busy_s;
        bit_tick  = tick_s;
        tx_ready  = tx_ready_s;
        tx_err    = tx_err_s;
        raw_bit   = shift_r[0];
        raw_valid = (state_r == ST_SYNC) || (state_r == ST_DATA) || (state_r == ST_TAIL);
        eop_se0   = (state_r == ST_EOP_SE0);
        eop_j     = (state_r == ST_EOP_J);
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
module tb_usb_tx_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       stuff_next;
    logic       sel;

    logic a_tx_valid, a_tx_ready, a_bit_tick, a_raw_bit, a_raw_valid;
    logic a_eop_se0, a_eop_j, a_busy, a_tx_err;
    logic b_tx_valid, b_tx_ready, b_bit_tick, b_raw_bit, b_raw_valid;
    logic b_eop_se0, b_eop_j, b_busy, b_tx_err;

    assign a_tx_valid = tx_valid & ~sel;
    assign b_tx_valid = tx_valid & sel;

    usb_tx_sequencer #(.CLKS_PER_BIT(8), .SYNC_PATTERN(8'h80), .EOP_SE0_BITS(2)) u_dut_a (
        .clk(clk), .rst(rst), .tx_valid(a_tx_valid), .tx_data(tx_data), .tx_last(tx_last),
        .tx_ready(a_tx_ready), .stuff_next(stuff_next), .bit_tick(a_bit_tick),
        .raw_bit(a_raw_bit), .raw_valid(a_raw_valid), .eop_se0(a_eop_se0), .eop_j(a_eop_j),
        .busy(a_busy), .tx_err(a_tx_err)
    );

    usb_tx_sequencer #(.CLKS_PER_BIT(4), .SYNC_PATTERN(8'h80), .EOP_SE0_BITS(3)) u_dut_b (
        .clk(clk), .rst(rst), .tx_valid(b_tx_valid), .tx_data(tx_data), .tx_last(tx_last),
        .tx_ready(b_tx_ready), .stuff_next(stuff_next), .bit_tick(b_bit_tick),
        .raw_bit(b_raw_bit), .raw_valid(b_raw_valid), .eop_se0(b_eop_se0), .eop_j(b_eop_j),
        .busy(b_busy), .tx_err(b_tx_err)
    );

    // Observed vector: {busy, raw_valid, raw_bit, eop_se0, eop_j, bit_tick, tx_ready, tx_err}
    logic [7:0] vec_a, vec_b, obs;
    assign vec_a = {a_busy, a_raw_valid, a_raw_bit, a_eop_se0, a_eop_j, a_bit_tick, a_tx_ready, a_tx_err};
    assign vec_b = {b_busy, b_raw_valid, b_raw_bit, b_eop_se0, b_eop_j, b_bit_tick, b_tx_ready, b_tx_err};
    assign obs   = sel ? vec_b : vec_a;

    int total = 0;
    int bad   = 0;

    // Reference model: expected bit-time sequence of one packet.
    // kind: 0 = bit on stuffer path, 1 = SE0, 2 = J
    logic [7:0] pk_bytes [0:7];
    bit         plan  [0:1023];
    logic [1:0] kind  [0:1023];
    bit         ebit  [0:1023];
    bit         care  [0:1023];
    bit         erdy  [0:1023];
    bit         eerr  [0:1023];
    int         exp_len;
    int         cpb;
    int         eop_bits;

    // Per-packet counts observed on the DUT outputs.
    int n_ready, n_err, n_busy, n_se0, n_j, n_rv;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_bt(input logic [1:0] k, input bit b, input bit c);
        kind[exp_len] = k;
        ebit[exp_len] = b;
        care[exp_len] = c;
        erdy[exp_len] = 1'b0;
        eerr[exp_len] = 1'b0;
        exp_len++;
    endtask

    // Build the expected bit times from the byte list, availability and stuff plan.
    task automatic build_model(input int n, input int navail);
        bit       bits [0:71];
        int       nb;
        int       t;
        bit       s;
        bit       done;
        bit       complete;
        int       bn;
        logic [7:0] sync_v;
        sync_v = 8'h80;
        for (int j = 0; j < 8; j++) bits[j] = sync_v[j];
        for (int k = 0; k < navail; k++)
            for (int j = 0; j < 8; j++) bits[8 + 8*k + j] = pk_bytes[k][j];
        nb = 8 + 8*navail;
        complete = (navail == n);
        exp_len = 0;
        t = 0;
        done = 1'b0;
        for (int i = 0; i < nb && !done; i++) begin
            push_bt(2'd0, bits[i], 1'b1);
            s = plan[t];
            t++;
            if ((i % 8) == 7) begin
                bn = i / 8;
                if (bn < navail) begin
                    erdy[exp_len-1] = 1'b1;
                end else begin
                    if (complete) begin
                        if (s) push_bt(2'd0, 1'b0, 1'b0);
                    end else begin
                        eerr[exp_len-1] = 1'b1;
                    end
                    done = 1'b1;
                end
            end
            while (!done && s) begin
                push_bt(2'd0, bits[i+1], 1'b1);
                s = (t < 1023) ? plan[t] : 1'b0;
                t++;
            end
        end
        for (int e = 0; e < eop_bits; e++) push_bt(2'd1, 1'b0, 1'b0);
        push_bt(2'd2, 1'b0, 1'b0);
    endtask

    task automatic plan_zero();
        for (int i = 0; i < 1024; i++) plan[i] = 1'b0;
    endtask

    task automatic plan_rand();
        for (int i = 0; i < 1024; i++) plan[i] = ($urandom_range(0, 3) == 0);
    endtask

    // Plan of an ideal stuffer: request a stuffed bit after six consecutive ones.
    task automatic plan_stuffer(input int n);
        logic [7:0] sync_v;
        int t;
        int ones;
        bit b;
        sync_v = 8'h80;
        plan_zero();
        t = 0;
        ones = 0;
        for (int i = 0; i < 8 + 8*n; i++) begin
            b = (i < 8) ? sync_v[i] : pk_bytes[(i-8)/8][(i-8)%8];
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
                plan[t] = 1'b1;
                t += 2;
                ones = 0;
            end else begin
                t++;
            end
        end
    endtask

    // Drive one packet and compare every cycle against the model.
    task automatic run_packet(input string tag, input bit sel_i, input int n, input int navail,
                              input bit hold, input int abort_at);
        int acc;
        int bt;
        bit tk;
        bit stop;
        logic [7:0] ev, gv;
        sel = sel_i;
        cpb = sel_i ? 4 : 8;
        eop_bits = sel_i ? 3 : 2;
        build_model(n, navail);
        n_ready = 0; n_err = 0; n_busy = 0; n_se0 = 0; n_j = 0; n_rv = 0;
        acc = 0;
        stop = 1'b0;
        @(negedge clk);
        tx_valid   = 1'b1;
        tx_data    = (navail > 0) ? pk_bytes[0] : 8'($urandom);
        tx_last    = (n == 1) && (navail == 1);
        stuff_next = 1'b0;
        #1;
        gv = obs; gv[5] = 1'b0;
        check_val({tag, " idle_start"}, 32'(gv), 32'd0);
        for (int c = 0; c <= exp_len*cpb && !stop; c++) begin
            @(negedge clk);
            bt = c / cpb;
            if (acc < navail) begin
                tx_valid = 1'b1; tx_data = pk_bytes[acc]; tx_last = (acc == n-1);
            end else if (hold && (navail == n) && (c < exp_len*cpb)) begin
                tx_valid = 1'b1; tx_data = 8'($urandom); tx_last = 1'($urandom);
            end else begin
                tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
            end
            stuff_next = (bt < 1024) ? plan[bt] : 1'b0;
            #1;
            gv = obs;
            if (c < exp_len*cpb) begin
                tk = ((c % cpb) == cpb - 1);
                ev = {1'b1, kind[bt] == 2'd0, care[bt] & ebit[bt], kind[bt] == 2'd1,
                      kind[bt] == 2'd2, tk, tk & erdy[bt], tk & eerr[bt]};
                if (!care[bt]) gv[5] = 1'b0;
            end else begin
                ev = 8'h00;
                gv[5] = 1'b0;
            end
            check_val($sformatf("%s c=%0d", tag, c), 32'(gv), 32'(ev));
            n_busy  += int'(obs[7]);
            n_rv    += int'(obs[6]);
            n_se0   += int'(obs[4]);
            n_j     += int'(obs[3]);
            n_ready += int'(obs[1]);
            n_err   += int'(obs[0]);
            if (tx_valid && obs[1]) acc++;
            if (c == abort_at) begin
                rst = 1'b1;
                tx_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                #1;
                check_val({tag, " after_rst"}, 32'(obs), 32'd0);
                @(negedge clk);
                #1;
                check_val({tag, " after_rst_idle"}, 32'(obs), 32'd0);
                stop = 1'b1;
            end
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        stuff_next = 1'b0;
    endtask

    initial begin
        int n, navail;
        bit hold;
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        stuff_next = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("reset_a", 32'(vec_a), 32'd0);
        check_val("reset_b", 32'(vec_b), 32'd0);
        rst = 1'b0;

        // Single byte A5, no stuffing: 19 bit times of 8 clocks.
        pk_bytes[0] = 8'hA5;
        plan_zero();
        run_packet("t2_a5", 1'b0, 1, 1, 1'b0, -1);
        check_val("t2_busy_cycles", 32'(n_busy), 32'd152);
        check_val("t2_ready", 32'(n_ready), 32'd1);
        check_val("t2_se0_cycles", 32'(n_se0), 32'd16);
        check_val("t2_j_cycles", 32'(n_j), 32'd8);

        // FF then 01 with a stuffer-driven plan: one stuffed bit.
        pk_bytes[0] = 8'hFF; pk_bytes[1] = 8'h01;
        plan_stuffer(2);
        run_packet("t3_ff01", 1'b0, 2, 2, 1'b0, -1);
        check_val("t3_ready", 32'(n_ready), 32'd2);
        check_val("t3_busy_cycles", 32'(n_busy), 32'd224);
        check_val("t3_rv_cycles", 32'(n_rv), 32'd200);

        // FC as last byte: stuff request at the final tick gives TAIL.
        pk_bytes[0] = 8'hFC;
        plan_stuffer(1);
        run_packet("t4_fc", 1'b0, 1, 1, 1'b0, -1);
        check_val("t4_rv_cycles", 32'(n_rv), 32'd136);
        check_val("t4_busy_cycles", 32'(n_busy), 32'd160);

        // Underrun at the second byte boundary.
        pk_bytes[0] = 8'h3C; pk_bytes[1] = 8'h99;
        plan_zero();
        run_packet("t5_underrun", 1'b0, 2, 1, 1'b0, -1);
        check_val("t5_ready", 32'(n_ready), 32'd1);
        check_val("t5_err", 32'(n_err), 32'd1);

        // Other parameter set: 4 clocks per bit, 3 SE0 bit times.
        pk_bytes[0] = 8'h5A;
        plan_zero();
        run_packet("t6_param", 1'b1, 1, 1, 1'b0, -1);
        check_val("t6_se0_cycles", 32'(n_se0), 32'd12);
        check_val("t6_j_cycles", 32'(n_j), 32'd4);

        // Reset in the middle of DATA.
        pk_bytes[0] = 8'h12; pk_bytes[1] = 8'h34;
        plan_zero();
        run_packet("t1_abort", 1'b0, 2, 2, 1'b0, 10*8 + 3);
        check_val("t1_err", 32'(n_err), 32'd0);

        // tx_valid held high through EOP after the last byte.
        pk_bytes[0] = 8'h81; pk_bytes[1] = 8'h7E;
        plan_rand();
        run_packet("hold", 1'b0, 2, 2, 1'b1, -1);
        check_val("hold_ready", 32'(n_ready), 32'd2);

        // Underrun right at SYNC end.
        plan_rand();
        run_packet("sync_underrun", 1'b0, 1, 0, 1'b0, -1);
        check_val("sync_underrun_err", 32'(n_err), 32'd1);

        // Randomised packets on both parameter sets.
        for (int r = 0; r < 24; r++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < 8; k++) pk_bytes[k] = 8'($urandom);
            navail = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : n;
            hold = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) plan_rand(); else plan_stuffer(navail);
            run_packet($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), n, navail, hold, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
